yarvi_uart_tx: RTL and testbench
================================

Name: yarvi_uart_tx

Overview:
- Downstream consumer of the SoC's host-bound byte stream (tx_valid/tx_data).
- The SoC raises tx_valid for exactly one cycle per MMIO byte store and never waits on tx_ready, so this block must absorb bursts.
- Bytes are buffered in a small FIFO and serialized as 8N1 UART frames on a single txd pin.
- Overflow is flagged, never silently stalled.

Parameters:
- CLK_DIV, 100, clock cycles per UART bit; legal range ≥ 2.
- FIFO_LOG2, 4, log2 of FIFO depth (default depth 16 entries).

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  byte strobe from SoC tx_valid.
- in_data  input  8  byte from SoC tx_data.
- in_ready  output  1  FIFO not full; wired to SoC tx_ready, advisory only.
- txd  output  1  serial line, idles high.
- busy  output  1  FIFO non-empty or frame in progress.
- overflow  output  1  sticky: a byte was dropped.
- count  output  FIFO_LOG2+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, released synchronously by the clock edge), all values while reset is high and after release:
  - txd=1, in_ready=1, busy=0, overflow=0, count=0.
  - FSM=IDLE; FIFO pointers, bit counter and baud counter all 0.
- Reset mid-frame aborts the frame immediately (txd=1) and discards all FIFO contents.
- FIFO push:
  - Occurs on an edge where in_valid=1 and count<2^FIFO_LOG2.
  - If in_valid=1 while full, the byte is dropped and overflow sets on that edge. overflow stays set until reset.
  - in_ready = (count != 2^FIFO_LOG2), evaluated from registered state. A push while full is rejected even if a pop happens on the same edge.
  - Simultaneous push and pop when not full leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP. Baud counter bc counts 0..CLK_DIV-1; bit index bi counts 0..7.
- IDLE:
  - txd=1.
  - If count≠0: pop head into shift register, txd←0, bc←0, go to START.
  - A byte pushed on edge E into an empty FIFO with FSM idle is popped on edge E+1; txd is low from E+1.
- START: hold txd=0 for CLK_DIV cycles. When bc=CLK_DIV-1: txd←shift[0], bi←0, go to DATA.
- DATA:
  - LSB first, each bit held CLK_DIV cycles.
  - At bc=CLK_DIV-1: if bi=7, txd←1 and go to STOP; else shift right, bi++, txd←next bit.
- STOP: hold txd=1 for CLK_DIV cycles. When bc=CLK_DIV-1:
  - If count≠0: pop next byte, txd←0, go to START. No idle gap between frames.
  - Else go to IDLE.
- Frame length is exactly 10·CLK_DIV cycles.
- Pop happens only on an IDLE→START or STOP→START edge. A push on that same edge is legal and counted.
- busy = (state≠IDLE) || (count≠0).
- Pointer arithmetic is modulo 2^FIFO_LOG2. count uses one extra bit so it can distinguish full from empty.
- txd is a register output: no combinational path from any input.

Test Plan:
- Single byte (CLK_DIV=4): push 0xA5 when idle.
  - txd low from the next edge for 4 cycles.
  - Then data bits 1,0,1,0,0,1,0,1, each 4 cycles.
  - Then high for 4 cycles; busy drops at the 40th cycle after the start edge.
- Back-to-back: push 0x00 and 0xFF on consecutive cycles.
  - Two frames, 80 cycles total, with no idle cycle between the stop bit and the second start bit.
  - count reads 1 after the first pop.
- Overflow (FIFO_LOG2=2): push 6 bytes on consecutive cycles starting idle.
  - First byte is popped immediately; bytes 2–5 fill the FIFO (count=4, in_ready=0).
  - Byte 6 is dropped and overflow=1.
  - Exactly 5 frames appear on txd; overflow stays 1 afterwards.
- Push on the pop edge: with the FIFO full and STOP ending, assert in_valid on the pop edge.
  - The byte is dropped (in_ready was 0) and overflow sets.
  - Repeat with count=3: the byte is accepted and count stays 3.
- Reset mid-frame: assert reset during DATA bit 3.
  - txd=1, count=0, busy=0 immediately, without waiting for a clock edge.
  - After release, no residual frame is transmitted.
- Loopback: a bench UART receiver decodes 256 random bytes pushed at random gaps ≥ 10·CLK_DIV.
  - All bytes are received in order; overflow=0.

Source files
------------

// File: rtl/yarvi_uart_tx.sv
// yarvi_uart_tx: FIFO-buffered 8N1 UART transmitter that absorbs unthrottled byte strobes.
// Overflowing bytes are dropped and flagged with a sticky overflow bit.
module yarvi_uart_tx #(
    parameter int CLK_DIV   = 100,
    parameter int FIFO_LOG2 = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 txd,
    output logic                 busy,
    output logic                 overflow,
    output logic [FIFO_LOG2:0]   count
);
    localparam int BCW = $clog2(CLK_DIV);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t               r_state, w_state_n;
    logic [7:0]           r_mem [1<<FIFO_LOG2];
    logic [FIFO_LOG2-1:0] r_wp, r_rp;
    logic [FIFO_LOG2:0]   r_count;
    logic [7:0]           r_shift;
    logic [BCW-1:0]       r_bc;
    logic [2:0]           r_bi;
    logic                 r_txd, r_ovf;
    logic                 w_full, w_nempty, w_push, w_pop, w_last, w_txd_n;
    // Occupancy never exceeds the depth, so the extra MSB alone marks full.
    assign w_full   = r_count[FIFO_LOG2];
    assign w_nempty = |r_count;
    assign w_push   = in_valid & ~w_full;
    assign w_last   = r_bc == BCW'(CLK_DIV - 1);
    always_comb begin
        w_state_n = r_state;
        w_pop     = 1'b0;
        w_txd_n   = r_txd;
        case (r_state)
            IDLE: begin
                w_txd_n = ~w_nempty;
                w_pop   = w_nempty;
                if (w_nempty) w_state_n = START;
            end
            START: if (w_last) begin
                w_txd_n   = r_shift[0];
                w_state_n = DATA;
            end
            DATA: if (w_last) begin
                w_txd_n = r_bi == 3'd7 ? 1'b1 : r_shift[1];
                if (r_bi == 3'd7) w_state_n = STOP;
            end
            STOP: if (w_last) begin
                w_pop     = w_nempty;
                w_txd_n   = ~w_nempty;
                w_state_n = w_nempty ? START : IDLE;
            end
            default: w_state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_txd   <= 1'b1;
            r_count <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_ovf   <= 1'b0;
            r_bc    <= '0;
            r_bi    <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_n;
            r_txd   <= w_txd_n;
            r_count <= r_count + (FIFO_LOG2+1)'(w_push) - (FIFO_LOG2+1)'(w_pop);
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_ovf <= r_ovf | (in_valid & w_full);
            r_bc  <= (r_state == IDLE || w_last) ? '0 : r_bc + 1'b1;
            if (w_pop) r_shift <= r_mem[r_rp];
            else if (r_state == DATA && w_last) r_shift <= r_shift >> 1;
            if (r_state == START) r_bi <= '0;
            else if (r_state == DATA && w_last) r_bi <= r_bi + 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wp] <= in_data;
    end
    assign in_ready = ~w_full;
    assign txd      = r_txd;
    assign busy     = (r_state != IDLE) | w_nempty;
    assign overflow = r_ovf;
    assign count    = r_count;
endmodule

// File: tb/tb_yarvi_uart_tx.sv
// tb_yarvi_uart_tx: frame-table, corner-case and random loopback checks for yarvi_uart_tx.
module tb_yarvi_uart_tx;
    localparam int D = 4;
    localparam int L = 2;
    logic clock = 1'b0, reset = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_ready, txd, busy, overflow;
    logic [L:0] count;
    int checks = 0, errors = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;
    vec_t vecs[6];

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic       rx_act = 1'b0;
    int         rx_t = 0, rx_ferr = 0;
    logic [7:0] rx_b;

    always #5 clock = ~clock;

    yarvi_uart_tx #(.CLK_DIV(D), .FIFO_LOG2(L)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .txd(txd), .busy(busy), .overflow(overflow), .count(count)
    );

    // Independent line receiver: samples each bit near its centre and keeps decoded bytes.
    always @(negedge clock) begin
        if (reset) rx_act = 1'b0;
        else if (!rx_act) begin
            if (txd == 1'b0) begin
                rx_act = 1'b1;
                rx_t = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % D == D / 2 && rx_t < 9 * D) rx_b[rx_t / D - 1] = txd;
            if (rx_t == 9 * D + D / 2) begin
                if (txd) rx_q.push_back(rx_b);
                else rx_ferr++;
                rx_act = 1'b0;
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic push_burst(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data = 8'($urandom);
            exp_q.push_back(in_data);
            tick;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int t = 0;
        while (rx_q.size() < n && t < 60 * D * (n + 1)) begin
            tick;
            t++;
        end
        chk("rx_count", rx_q.size(), n);
    endtask

    task automatic cmp_rx;
        for (int i = 0; i < exp_q.size(); i++)
            if (i < rx_q.size()) chk("rx_byte", rx_q[i], exp_q[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] f0, f1;
        int lows;
        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h01, 10'b1000000010};
        vecs[4] = '{8'h80, 10'b1100000000};
        vecs[5] = '{8'h3C, 10'b1001111000};

        #1 reset = 1'b1;
        #2;
        chk("rst_txd", txd, 1);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_count", count, 0);
        tick;
        tick;
        reset = 1'b0;
        tick;
        chk("rel_txd", txd, 1);
        chk("rel_busy", busy, 0);
        chk("rel_count", count, 0);
        chk("rel_ready", in_ready, 1);

        foreach (vecs[v]) begin
            rx_q.delete();
            in_valid = 1'b1;
            in_data = vecs[v].data;
            tick;
            in_valid = 1'b0;
            tick;
            for (int k = 0; k < 10 * D; k++) begin
                chk("frame_txd", txd, vecs[v].frame[k / D]);
                if (k == 10 * D - 1) chk("frame_busy", busy, 1);
                tick;
            end
            chk("frame_busy_drop", busy, 0);
            chk("frame_idle_txd", txd, 1);
            chk("frame_rx_n", rx_q.size(), 1);
            if (rx_q.size() > 0) chk("frame_rx", rx_q[0], vecs[v].data);
        end

        f0 = 10'b1000000000;
        f1 = 10'b1111111110;
        in_valid = 1'b1;
        in_data = 8'h00;
        tick;
        in_data = 8'hFF;
        tick;
        in_valid = 1'b0;
        chk("b2b_count", count, 1);
        for (int k = 0; k < 20 * D; k++) begin
            chk("b2b_txd", txd, k < 10 * D ? f0[k / D] : f1[k / D - 10]);
            tick;
        end
        chk("b2b_busy", busy, 0);

        do_reset;
        push_burst(5);
        chk("ovf_count4", count, 4);
        chk("ovf_ready0", in_ready, 0);
        chk("ovf_pre", overflow, 0);
        push_burst(1);
        void'(exp_q.pop_back());
        chk("ovf_set", overflow, 1);
        chk("ovf_count_hold", count, 4);
        wait_rx(5);
        cmp_rx;
        repeat (15 * D) tick;
        chk("ovf_frames", rx_q.size(), 5);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_idle", busy, 0);

        do_reset;
        chk("ovf_cleared", overflow, 0);
        push_burst(5);
        repeat (36) tick;
        chk("pe_full_ready", in_ready, 0);
        chk("pe_stop_txd", txd, 1);
        in_valid = 1'b1;
        in_data = 8'h5A;
        tick;
        in_valid = 1'b0;
        chk("pe_full_ovf", overflow, 1);
        chk("pe_full_count", count, 3);
        chk("pe_full_start", txd, 0);
        wait_rx(5);
        cmp_rx;

        do_reset;
        push_burst(4);
        repeat (37) tick;
        chk("pe3_count_pre", count, 3);
        chk("pe3_ready", in_ready, 1);
        push_burst(1);
        chk("pe3_count", count, 3);
        chk("pe3_ovf", overflow, 0);
        chk("pe3_start", txd, 0);
        wait_rx(5);
        cmp_rx;

        do_reset;
        in_valid = 1'b1;
        in_data = 8'hF0;
        tick;
        push_burst(2);
        repeat (16) tick;
        chk("mid_bit3", txd, 0);
        chk("mid_count", count, 2);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_txd", txd, 1);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_busy", busy, 0);
        tick;
        reset = 1'b0;
        rx_q.delete();
        lows = 0;
        for (int k = 0; k < 25 * D; k++) begin
            if (txd !== 1'b1) lows++;
            tick;
        end
        chk("mid_no_residual", lows, 0);
        chk("mid_busy_after", busy, 0);
        chk("mid_rx_none", rx_q.size(), 0);

        do_reset;
        rx_ferr = 0;
        for (int i = 0; i < 256; i++) begin
            push_burst(1);
            repeat ($urandom_range(10 * D, 15 * D)) tick;
        end
        wait_rx(256);
        cmp_rx;
        chk("lb_ovf", overflow, 0);
        chk("lb_ferr", rx_ferr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
